// File: rtl/irq_trap_ctrl_if.sv
// Bundle between the trap sequencer and its neighbours: the pipeline EX stage,
// the machine-mode CSR file and the asynchronous external interrupt line.
// master: the pipeline/CSR side that supplies requests and consumes strobes.
// slave:  the trap sequencer itself.
interface irq_trap_ctrl_if;
  logic        ext_irq;
  logic        meie;
  logic        mstatus_mie;
  logic [31:0] mtvec_pc;
  logic [31:0] mepc_pc;
  logic        ex_valid;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic        ex_wfi;
  logic        ex_mret;
  logic        ex_branch_taken;
  logic        ex_csr_write;
  logic        interrupt;
  logic        mret;
  logic [31:0] trap_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        wfi_stall;

  modport master (
    output ext_irq, meie, mstatus_mie, mtvec_pc, mepc_pc,
    output ex_valid, ex_stall, ex_pc, ex_wfi, ex_mret, ex_branch_taken, ex_csr_write,
    input  interrupt, mret, trap_pc, redirect, redirect_pc, flush, wfi_stall
  );

  modport slave (
    input  ext_irq, meie, mstatus_mie, mtvec_pc, mepc_pc,
    input  ex_valid, ex_stall, ex_pc, ex_wfi, ex_mret, ex_branch_taken, ex_csr_write,
    output interrupt, mret, trap_pc, redirect, redirect_pc, flush, wfi_stall
  );
endinterface

// File: rtl/irq_trap_ctrl.sv
// Trap sequencer between the external interrupt line and the machine-mode CSR
// file. Synchronises ext_irq, decides when an interrupt is taken at an EX
// retire boundary, emits the one-cycle interrupt/MRET strobes with the mepc
// capture value, redirects and flushes the pipeline, and implements WFI sleep.
//
// Optional build macro IRQ_EDGE_EN: when defined, a rising edge of the
// synchronised request sets a pending flop that stands in for the level;
// otherwise the request is level-sensitive and must be held until serviced.
module irq_trap_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  irq_trap_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    TRAP  = 2'd1,
    SLEEP = 2'd2,
    RET   = 2'd3
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   irq_s;
  logic                   irq_src;
  logic                   wake_req;
  logic                   irq_ok;
  logic                   retire;
  logic                   inhibit;

  logic                   interrupt_q;
  logic                   mret_q;
  logic                   redirect_q;
  logic                   flush_q;
  logic                   wfi_stall_q;
  logic [31:0]            trap_pc_q;
  logic [31:0]            trap_target_q;

  // Shift the asynchronous request through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.ext_irq};
    end
  end

  assign irq_s = sync[SYNC_STAGES-1];

`ifdef IRQ_EDGE_EN
  logic irq_prev;
  logic pending;

  // Latch a rising edge of irq_s until trap entry consumes it; a fresh edge wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_prev <= 1'b0;
      pending  <= 1'b0;
    end else begin
      irq_prev <= irq_s;
      pending  <= (irq_s & ~irq_prev) | (pending & (state != TRAP));
    end
  end

  assign irq_src = pending;
`else
  assign irq_src = irq_s;
`endif

  // WFI wakes on the locally enabled request regardless of the global enable;
  // an actual take additionally needs mstatus.MIE.
  assign wake_req = irq_src & bus.meie;
  assign irq_ok   = wake_req & bus.mstatus_mie;
  assign retire   = bus.ex_valid & ~bus.ex_stall;
  // CSR writes outrank the trap in the CSR file, and a redirecting instruction
  // would make the mepc+4 return target wrong, so neither may be interrupted.
  assign inhibit  = bus.ex_mret | bus.ex_branch_taken | bus.ex_csr_write;

  // Trap state machine; every strobe is a flop decoded from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      interrupt_q   <= 1'b0;
      mret_q        <= 1'b0;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      wfi_stall_q   <= 1'b0;
      trap_pc_q     <= '0;
      trap_target_q <= '0;
    end else begin
      interrupt_q   <= 1'b0;
      mret_q        <= 1'b0;
      redirect_q    <= 1'b0;
      flush_q       <= 1'b0;
      wfi_stall_q   <= 1'b0;
      trap_target_q <= '0;
      case (state)
        RUN: begin
          if (retire && irq_ok && !inhibit) begin
            state         <= TRAP;
            trap_pc_q     <= bus.ex_pc;
            trap_target_q <= bus.mtvec_pc;
            interrupt_q   <= 1'b1;
            redirect_q    <= 1'b1;
            flush_q       <= 1'b1;
          end else if (retire && bus.ex_mret) begin
            state      <= RET;
            mret_q     <= 1'b1;
            redirect_q <= 1'b1;
            flush_q    <= 1'b1;
          end else if (retire && bus.ex_wfi && !wake_req) begin
            state       <= SLEEP;
            trap_pc_q   <= bus.ex_pc;
            wfi_stall_q <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        TRAP: begin
          state <= RUN;
        end
        RET: begin
          state <= RUN;
        end
        SLEEP: begin
          if (wake_req) begin
            if (bus.mstatus_mie) begin
              state         <= TRAP;
              trap_target_q <= bus.mtvec_pc;
              interrupt_q   <= 1'b1;
              redirect_q    <= 1'b1;
              flush_q       <= 1'b1;
            end else begin
              state <= RUN;
            end
          end else begin
            state       <= SLEEP;
            wfi_stall_q <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // In RET the return target is taken straight from the CSR file so it
  // reflects mepc as it stands in that cycle.
  assign bus.redirect_pc = (state == RET) ? bus.mepc_pc : trap_target_q;
  assign bus.interrupt   = interrupt_q;
  assign bus.mret        = mret_q;
  assign bus.redirect    = redirect_q;
  assign bus.flush       = flush_q;
  assign bus.wfi_stall   = wfi_stall_q;
  assign bus.trap_pc     = trap_pc_q;

endmodule
